// File: rtl/pcie_ss_sched_pkg.sv
// Shared types and defaults for the PCIe SS AXI-S weighted round-robin scheduler.
//   weight_t       : default-width per-channel weight
//   sched_state_e  : which path of the grant select logic is active (debug view)
package pcie_ss_sched_pkg;

  localparam int SCHED_WEIGHT_W       = 4;
  localparam int SCHED_DEFAULT_WEIGHT = 1;

  typedef logic [SCHED_WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    STAY,
    SWITCH,
    LOCKED
  } sched_state_e;

endpackage

// File: rtl/pcie_ss_rr_find_first.sv
// Rotating-priority find-first-set.
//   req    : request vector
//   start  : index with highest priority; search runs start, start+1, ... (wrap)
//   onehot : first set request found, one-hot (zero when none)
//   idx    : index of that request (zero when none)
//   found  : any request set
module pcie_ss_rr_find_first #(
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  int               tmp;
  logic [SEL_W-1:0] pos;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    tmp    = 0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      tmp = int'(start) + i;
      if (tmp >= N) tmp = tmp - N;
      pos = SEL_W'(tmp);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/pcie_ss_axis_wrr_sched.sv
// Packet-granular weighted round-robin scheduler for an AXI-S N:1 mux.
// Only the select decision lives here; the datapath mux is external.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_last: per-channel head-beat tvalid / tlast
//   out_ready       : mux output accepts a beat this cycle
//   grant_*         : combinational selection (valid, one-hot, index)
//   cfg_*           : weight CSR; write strobe, channel select, wdata, registered rdata
module pcie_ss_axis_wrr_sched
  import pcie_ss_sched_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int WEIGHT_W       = SCHED_WEIGHT_W,
  parameter  int DEFAULT_WEIGHT = SCHED_DEFAULT_WEIGHT,
  localparam int SEL_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [NUM_CH-1:0]   in_last,
  input  logic                out_ready,
  output logic                grant_valid,
  output logic [NUM_CH-1:0]   grant_1hot,
  output logic [SEL_W-1:0]    grant_idx,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_ch,
  input  logic [WEIGHT_W-1:0] cfg_wdata,
  output logic [WEIGHT_W-1:0] cfg_rdata
);

  logic [SEL_W-1:0]                 cur;
  logic [WEIGHT_W-1:0]              credit;
  logic                             in_pkt;
  logic [NUM_CH-1:0][WEIGHT_W-1:0]  weight;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] ff_1hot;
  logic [SEL_W-1:0]  ff_idx;
  logic              ff_found;
  logic [SEL_W-1:0]  start;
  logic [SEL_W-1:0]  sel;
  logic              xfer;
  logic              cfg_hit;
  sched_state_e      state;

  // A channel can open a new packet only if it is valid and not disabled.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_elig
    assign elig[c] = in_valid[c] & (|weight[c]);
  end

  // Search begins one past the current owner so the owner itself is tried last.
  assign start = (cur == SEL_W'(NUM_CH-1)) ? '0 : cur + SEL_W'(1);

  pcie_ss_rr_find_first #(
    .N     (NUM_CH),
    .SEL_W (SEL_W)
  ) u_ff (
    .req    (elig),
    .start  (start),
    .onehot (ff_1hot),
    .idx    (ff_idx),
    .found  (ff_found)
  );

  always_comb begin
    state       = IDLE;
    sel         = cur;
    grant_valid = 1'b0;
    if (in_pkt) begin
      // Mid-packet: owner is held regardless of weight or other requesters.
      state       = LOCKED;
      grant_valid = in_valid[cur];
    end else if (credit != '0 && elig[cur]) begin
      state       = STAY;
      grant_valid = 1'b1;
    end else if (ff_found) begin
      state       = SWITCH;
      sel         = ff_idx;
      grant_valid = 1'b1;
    end
    grant_1hot = '0;
    if (grant_valid) grant_1hot = ff_1hot;
    if (grant_valid && state != SWITCH) begin
      grant_1hot      = '0;
      grant_1hot[sel] = 1'b1;
    end
    grant_idx = grant_valid ? sel : '0;
  end

  assign xfer = grant_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= SEL_W'(NUM_CH-1);
      credit <= '0;
      in_pkt <= 1'b0;
    end else if (xfer) begin
      in_pkt <= ~in_last[sel];
      case (state)
        // Credit counts whole packets, so it only moves on the tlast beat.
        STAY, LOCKED: if (in_last[sel] && credit != '0) credit <= credit - WEIGHT_W'(1);
        // Reload reads the registered weight, i.e. the pre-write value on a same-cycle CSR write.
        SWITCH: begin
          cur    <= sel;
          credit <= weight[sel] - WEIGHT_W'(in_last[sel]);
        end
        default: ;
      endcase
    end
  end

  assign cfg_hit = (int'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) weight[c] <= WEIGHT_W'(DEFAULT_WEIGHT);
      cfg_rdata <= '0;
    end else begin
      if (cfg_we && cfg_hit) weight[cfg_ch] <= cfg_wdata;
      cfg_rdata <= cfg_hit ? weight[cfg_ch] : '0;
    end
  end

endmodule

// File: tb/tb_pcie_ss_axis_wrr_sched.sv
module tb_pcie_ss_axis_wrr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_last = '0;
  logic       out_ready = 1'b0;
  logic       grant_valid;
  logic [3:0] grant_1hot;
  logic [1:0] grant_idx;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [3:0] cfg_wdata = '0;
  logic [3:0] cfg_rdata;

  pcie_ss_axis_wrr_sched #(.NUM_CH(4), .WEIGHT_W(4), .DEFAULT_WEIGHT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_1hot  (grant_1hot),
    .grant_idx   (grant_idx),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic       gv;
    logic [1:0] idx;
    logic       crd;
    logic [3:0] rd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  int seq_rr[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq_w[10]   = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1};
  int seq_fo[5]   = '{0, 0, 0, 0, 1};
  int seq_dis[7]  = '{3, 0, 0, 0, 0, 1, 3};

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] e1h;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        e1h = '0;
        if (e.gv) e1h[e.idx] = 1'b1;
        checks++;
        if (grant_valid !== e.gv) begin
          errors++;
          $display("FAIL grant_valid @%0t: got %0b expected %0b", $time, grant_valid, e.gv);
        end
        checks++;
        if (grant_idx !== (e.gv ? e.idx : 2'd0)) begin
          errors++;
          $display("FAIL grant_idx @%0t: got %0d expected %0d", $time, grant_idx, e.gv ? e.idx : 2'd0);
        end
        checks++;
        if (grant_1hot !== e1h) begin
          errors++;
          $display("FAIL grant_1hot @%0t: got %b expected %b", $time, grant_1hot, e1h);
        end
      end
      if (e.crd) begin
        checks++;
        if (cfg_rdata !== e.rd) begin
          errors++;
          $display("FAIL cfg_rdata @%0t: got %0d expected %0d", $time, cfg_rdata, e.rd);
        end
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                      input logic chk, input logic egv, input logic [1:0] eidx,
                      input logic crd, input logic [3:0] erd);
    exp_t e;
    in_valid  = v;
    in_last   = l;
    out_ready = rdy;
    e.chk = chk; e.gv = egv; e.idx = eidx; e.crd = crd; e.rd = erd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic g(input logic [3:0] v, input logic [3:0] l, input logic rdy, input int eidx);
    step(v, l, rdy, 1'b1, 1'b1, 2'(eidx), 1'b0, 4'd0);
  endtask

  task automatic wr(input int ch, input int val);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_wdata = 4'(val);
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0);
    cfg_we    = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: nothing valid -> no grant, rdata cleared.
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0);

    // Plain round-robin with default weights.
    for (int i = 0; i < 8; i++) g(4'hF, 4'hF, 1'b1, seq_rr[i]);

    // Weights {3,1,0,2}; read weight[0] back on the second cycle.
    wr(0, 3); wr(1, 1); wr(2, 0); wr(3, 2);
    cfg_ch = 2'd0;
    for (int i = 0; i < 10; i++)
      step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'(seq_w[i]), i == 1, 4'd3);

    // 5-beat packet on ch0 with stalls; ch1 waits until after tlast.
    wr(0, 1); wr(1, 1); wr(2, 1); wr(3, 1);
    g(4'b0011, 4'b0010, 1'b1, 0);
    g(4'b0011, 4'b0010, 1'b0, 0);
    g(4'b0011, 4'b0010, 1'b1, 0);
    g(4'b0011, 4'b0010, 1'b0, 0);
    g(4'b0011, 4'b0010, 1'b1, 0);
    g(4'b0011, 4'b0010, 1'b1, 0);
    g(4'b0011, 4'b0011, 1'b1, 0);
    g(4'b0010, 4'b0010, 1'b1, 1);

    // Credit forfeit: ch0 weight 4 drops valid after one packet.
    wr(0, 4);
    g(4'b0001, 4'b0001, 1'b1, 0);
    g(4'b0010, 4'b0010, 1'b1, 1);
    for (int i = 0; i < 5; i++) g(4'b0011, 4'b0011, 1'b1, seq_fo[i]);

    // Disable ch2 mid-packet; packet completes, ch2 never granted again.
    g(4'b0100, 4'b0000, 1'b1, 2);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_wdata = 4'd0;
    g(4'b0100, 4'b0000, 1'b1, 2);
    cfg_we = 1'b0;
    g(4'b0100, 4'b0100, 1'b1, 2);
    for (int i = 0; i < 7; i++)
      step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'(seq_dis[i]), i == 0, 4'd0);

    // Reset in the middle of a ch1 packet.
    g(4'b0010, 4'b0000, 1'b1, 1);
    g(4'hF, 4'h0, 1'b1, 1);
    rst = 1'b1;
    step(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
    rst = 1'b0;
    cfg_ch = 2'd2;
    step(4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'd0);
    step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'd1);
    g(4'hF, 4'hF, 1'b1, 1);
    g(4'hF, 4'hF, 1'b1, 2);
    g(4'hF, 4'hF, 1'b1, 3);

    in_valid = '0;
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
